// File: rtl/life_gen_sched.sv
// Generation scheduler: divides clk into generation ticks and hands one start pulse per generation to the life engine.
// Optional: define LIFE_OVERRUN_STICKY_EN for a sticky overrun flag (cleared by reset or run=0); otherwise it is a one-cycle pulse.
module life_gen_sched #(
  parameter int               DIV_W       = 24,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(4_999_999),
  parameter int               GEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             rate_wr,
  input  logic [DIV_W-1:0] rate_in,
  input  logic             done,
  output logic             start,
  output logic             busy,
  output logic             tick,
  output logic             overrun,
  output logic [GEN_W-1:0] gen_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] rate_reg;
  logic [DIV_W-1:0] div_cnt;
  logic             dropped;
  logic             overrun_q;

  assign tick    = run && (div_cnt == '0);
  assign dropped = tick && (state != IDLE);
  assign overrun = overrun_q;

  // Divider: a pause parks the counter at the full period so resuming never yields a short first period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate_reg <= DEFAULT_DIV;
      div_cnt  <= DEFAULT_DIV;
    end else if (rate_wr) begin
      rate_reg <= rate_in;
      div_cnt  <= rate_in;
    end else if (!run || (div_cnt == '0)) begin
      div_cnt  <= rate_reg;
    end else begin
      div_cnt  <= div_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if ((run && tick) || (!run && step)) state_nxt = START;
      START:   state_nxt = BUSY;
      BUSY:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = (state == START);
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gen_count <= '0;
    end else if ((state == BUSY) && done) begin
      gen_count <= gen_count + 1'b1;
    end
  end

`ifdef LIFE_OVERRUN_STICKY_EN
  // Dropped ticks need run=1, so the clear on run=0 can never collide with a set.
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      overrun_q <= 1'b0;
    end else if (dropped) begin
      overrun_q <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= dropped;
    end
  end
`endif

endmodule

// File: tb/tb_life_gen_sched.sv
// Directed bench for life_gen_sched: divider, step, overrun, pause/resume, reset mid-generation and counter wrap.
// Latency: checks sample 2 time units after each clock edge.
// Backpressure: none; the bench drives done directly as the engine model.
module tb_life_gen_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        rate_wr;
    logic [23:0] rate_in;
    logic        done;
    logic        start;
    logic        busy;
    logic        tick;
    logic        overrun;
    logic [3:0]  gen_count;

    int checks   = 0;
    int failures = 0;

`ifdef LIFE_OVERRUN_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    life_gen_sched #(
        .DIV_W      (24),
        .DEFAULT_DIV(24'd5),
        .GEN_W      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .step     (step),
        .rate_wr  (rate_wr),
        .rate_in  (rate_in),
        .done     (done),
        .start    (start),
        .busy     (busy),
        .tick     (tick),
        .overrun  (overrun),
        .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0; rate_wr = 1'b0; rate_in = '0; done = 1'b0;
        go(2);

        rst_n = 1'b1; run = 1'b1;
        #1;
        chk("rst_busy", busy === 1'b0, busy, 1'b0);
        chk("rst_start", start === 1'b0, start, 1'b0);
        chk("rst_overrun", overrun === 1'b0, overrun, 1'b0);
        chk("rst_gen", gen_count === 4'd0, gen_count, 4'd0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) #1;
            chk("dflt_tick", tick === (i == 5), tick, (i == 5));
            go(1);
        end
        run = 1'b0;
        #1;
        chk("dflt_start", start === 1'b1, start, 1'b1);
        go(1);
        done = 1'b1;
        #1;
        chk("dflt_busy", busy === 1'b1, busy, 1'b1);
        go(1);
        done = 1'b0;
        #1;
        chk("dflt_gen", gen_count === 4'd1, gen_count, 4'd1);
        chk("dflt_idle", busy === 1'b0, busy, 1'b0);

        rate_wr = 1'b1; rate_in = 24'd3;
        go(1);
        rate_wr = 1'b0; run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int p = 0; p < 4; p++) begin
                done = (p == 1) && (k > 0);
                #1;
                chk("per_tick", tick === (p == 3), tick, (p == 3));
                chk("per_start", start === ((p == 0) && (k > 0)), start, ((p == 0) && (k > 0)));
                go(1);
            end
        end
        run = 1'b0;
        #1;
        chk("per_start_last", start === 1'b1, start, 1'b1);
        go(1);
        done = 1'b1;
        go(1);
        done = 1'b0;
        #1;
        chk("per_gen", gen_count === 4'd6, gen_count, 4'd6);
        chk("per_overrun", overrun === 1'b0, overrun, 1'b0);
        chk("per_idle", busy === 1'b0, busy, 1'b0);

        step = 1'b1;
        #1;
        chk("stp_nostart", start === 1'b0, start, 1'b0);
        go(1);
        step = 1'b0;
        #1;
        chk("stp_start", start === 1'b1, start, 1'b1);
        go(1);
        step = 1'b1;
        #1;
        chk("stp_busy", busy === 1'b1, busy, 1'b1);
        go(1);
        step = 1'b0; done = 1'b1;
        #1;
        chk("stp_ignored", start === 1'b0, start, 1'b0);
        go(1);
        done = 1'b1;
        #1;
        chk("stp_gen", gen_count === 4'd7, gen_count, 4'd7);
        chk("stp_idle", busy === 1'b0, busy, 1'b0);
        go(1);
        done = 1'b0;
        #1;
        chk("idle_done_ignored", gen_count === 4'd7, gen_count, 4'd7);

        run = 1'b1; rate_wr = 1'b1; rate_in = 24'd0;
        #1;
        chk("ovr_tick0", tick === 1'b0, tick, 1'b0);
        go(1);
        rate_wr = 1'b0;
        #1;
        chk("ovr_tick1", tick === 1'b1, tick, 1'b1);
        chk("ovr_start0", start === 1'b0, start, 1'b0);
        chk("ovr_flag0", overrun === 1'b0, overrun, 1'b0);
        go(1);
        #1;
        chk("ovr_start", start === 1'b1, start, 1'b1);
        chk("ovr_flag1", overrun === 1'b0, overrun, 1'b0);
        go(1);
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("ovr_hold_start", start === 1'b0, start, 1'b0);
            chk("ovr_hold_flag", overrun === 1'b1, overrun, 1'b1);
            go(1);
        end
        done = 1'b1; rate_wr = 1'b1; rate_in = 24'd3;
        #1;
        chk("ovr_tick_done", tick === 1'b1, tick, 1'b1);
        go(1);
        done = 1'b0; rate_wr = 1'b0;
        #1;
        chk("ovr_idle", busy === 1'b0, busy, 1'b0);
        chk("ovr_gen", gen_count === 4'd8, gen_count, 4'd8);
        chk("ovr_flag_last", overrun === 1'b1, overrun, 1'b1);
        chk("ovr_notick", tick === 1'b0, tick, 1'b0);
        go(1);
        #1;
        chk("ovr_sticky", overrun === STICKY, overrun, STICKY);
        chk("ovr_nostart", start === 1'b0, start, 1'b0);
        run = 1'b0;
        go(1);
        #1;
        chk("ovr_clear", overrun === 1'b0, overrun, 1'b0);

        run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("pr_pre_tick", tick === 1'b0, tick, 1'b0);
            go(1);
        end
        run = 1'b0;
        go(1);
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("pr_tick", tick === (i == 3), tick, (i == 3));
            go(1);
        end
        run = 1'b0;
        #1;
        chk("pr_start", start === 1'b1, start, 1'b1);
        go(1);
        done = 1'b1;
        go(1);
        done = 1'b0;
        #1;
        chk("pr_gen", gen_count === 4'd9, gen_count, 4'd9);

        step = 1'b1;
        go(1);
        step = 1'b0;
        go(1);
        #1;
        chk("rm_busy", busy === 1'b1, busy, 1'b1);
        rst_n = 1'b0;
        go(1);
        rst_n = 1'b1;
        #1;
        chk("rm_busy0", busy === 1'b0, busy, 1'b0);
        chk("rm_start0", start === 1'b0, start, 1'b0);
        chk("rm_gen0", gen_count === 4'd0, gen_count, 4'd0);
        done = 1'b1;
        go(1);
        done = 1'b0;
        #1;
        chk("rm_late_done", gen_count === 4'd0, gen_count, 4'd0);
        chk("rm_busy1", busy === 1'b0, busy, 1'b0);
        go(1);
        #1;
        chk("rm_nostart", start === 1'b0, start, 1'b0);

        for (int g = 1; g <= 16; g++) begin
            step = 1'b1;
            go(1);
            step = 1'b0;
            go(1);
            done = 1'b1;
            go(1);
            done = 1'b0;
            #1;
            chk("wrap_gen", gen_count === 4'(g), gen_count, 4'(g));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
